// File: rtl/shared_reg_arbiter_pkg.sv
// Shared declarations for the shared-register round-robin arbiter.
// Holds the FSM state encoding, default sizing constants and a small
// helper for pointer width. Optional feature macro: ARB_LOCK_EN.
package shared_reg_arb_pkg;

  localparam int ARB_N_DEF        = 4;
  localparam int ARB_W_DEF        = 8;
  localparam int ARB_MAX_LOCK_DEF = 4;
  localparam int ARB_STATE_W      = 2;

  typedef enum logic [ARB_STATE_W-1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  // Width needed to hold a requester index 0..n-1 (at least one bit).
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Bus between the requesters and the shared-register arbiter.
// Optional feature macro affecting LOCK usage: ARB_LOCK_EN.
//
// Handshake: a requester raises REQ[i] (with DIN[i] valid) and holds it
// until it observes GNT[i]; it drops REQ[i] in the cycle after GNT[i].
// GNT is the "ready" side: it is one-hot, registered, and is high only
// while REG_LD is high. REQ dropped before being sampled in IDLE is simply
// withdrawn. STATE mirrors the arbiter FSM for observation.
interface shared_reg_arbiter_if
  import shared_reg_arb_pkg::*;
#(
  parameter int N = ARB_N_DEF,
  parameter int W = ARB_W_DEF
);

  logic [N-1:0]           REQ;
  logic [N-1:0]           LOCK;
  logic [N*W-1:0]         DIN;
  logic [N-1:0]           GNT;
  logic                   REG_LD;
  logic [W-1:0]           REG_D;
  logic                   BUSY;
  logic [ARB_STATE_W-1:0] STATE;

  modport master (
    output REQ, LOCK, DIN,
    input  GNT, REG_LD, REG_D, BUSY, STATE
  );

  modport slave (
    input  REQ, LOCK, DIN,
    output GNT, REG_LD, REG_D, BUSY, STATE
  );

endinterface

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin search: starting after ptr_i, the first set
// request bit (modulo N) wins. Returns one-hot winner, index and valid.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);

  int cand;

  // Scan ptr+1, ptr+2, ... ptr+N and keep the first requester found.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr_i) + k) % N;
      if (!valid_o && req_i[cand]) begin
        valid_o        = 1'b1;
        onehot_o[cand] = 1'b1;
        idx_o          = cand[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter owning the data/load inputs of one shared W-bit
// register bank. One load per grant followed by a turnaround cycle.
// Optional feature macro: ARB_LOCK_EN (lets a locking requester keep the
// grant for up to MAX_LOCK consecutive load cycles).
module shared_reg_arbiter
  import shared_reg_arb_pkg::*;
#(
  parameter int N        = ARB_N_DEF,
  parameter int W        = ARB_W_DEF,
  parameter int MAX_LOCK = ARB_MAX_LOCK_DEF
) (
  input  logic                 CK,
  input  logic                 RST,
  shared_reg_arbiter_if.slave  bus
);

  localparam int PW = ptr_width(N);

  localparam logic [ARB_STATE_W-1:0] ST_IDLE    = IDLE;
  localparam logic [ARB_STATE_W-1:0] ST_GRANT   = GRANT;
  localparam logic [ARB_STATE_W-1:0] ST_RELEASE = RELEASE;

  logic [ARB_STATE_W-1:0] state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [N-1:0]           gnt_q, gnt_d;
  logic                   ld_q, ld_d;
  logic [W-1:0]           data_q, data_d;

  logic [N-1:0]           pick_onehot;
  logic [PW-1:0]          pick_idx;
  logic                   pick_valid;

`ifdef ARB_LOCK_EN
  localparam int LCW = $clog2(MAX_LOCK) + 1;
  logic [LCW-1:0]         lock_cnt_q, lock_cnt_d;
`else
  // LOCK and MAX_LOCK only matter when locking is compiled in.
  logic                   unused_lock;
  assign unused_lock = (^bus.LOCK) ^ (MAX_LOCK > 0);
`endif

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req_i    (bus.REQ),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  // Next-state logic: pick in IDLE, load for one cycle (or more while
  // locked), then spend one turnaround cycle in RELEASE.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    ld_d    = ld_q;
    data_d  = data_q;
`ifdef ARB_LOCK_EN
    lock_cnt_d = lock_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_onehot;
          ld_d    = 1'b1;
          data_d  = bus.DIN[int'(pick_idx)*W +: W];
          ptr_d   = pick_idx;
          state_d = ST_GRANT;
        end else begin
          gnt_d = '0;
          ld_d  = 1'b0;
        end
      end
      ST_GRANT: begin
`ifdef ARB_LOCK_EN
        if (bus.REQ[ptr_q] && bus.LOCK[ptr_q] &&
            (int'(lock_cnt_q) < MAX_LOCK - 1)) begin
          data_d     = bus.DIN[int'(ptr_q)*W +: W];
          lock_cnt_d = lock_cnt_q + 1'b1;
        end else begin
          gnt_d      = '0;
          ld_d       = 1'b0;
          lock_cnt_d = '0;
          state_d    = ST_RELEASE;
        end
`else
        gnt_d   = '0;
        ld_d    = 1'b0;
        state_d = ST_RELEASE;
`endif
      end
      ST_RELEASE: begin
        // Requests are deliberately not looked at during turnaround.
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        ld_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over any grant in flight.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      ptr_q   <= PW'(N - 1);
      gnt_q   <= '0;
      ld_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ld_q    <= ld_d;
      data_q  <= data_d;
    end
  end

`ifdef ARB_LOCK_EN
  // Consecutive-load counter for the current locked grant.
  always_ff @(posedge CK) begin
    if (RST) begin
      lock_cnt_q <= '0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
    end
  end
`endif

  assign bus.GNT    = gnt_q;
  assign bus.REG_LD = ld_q;
  assign bus.REG_D  = data_q;
  assign bus.BUSY   = (state_q != ST_IDLE);
  assign bus.STATE  = state_q;

endmodule
